// File: rtl/mgmt_regfile_pkg.sv
// rtl/mgmt_regfile_pkg.sv - register map, FSM encoding and helpers for mgmt_regfile
package mgmt_regfile_pkg;

    localparam logic [12:0] OFF_MSTATUS  = 13'h000;
    localparam logic [12:0] OFF_MVEC     = 13'h004;
    localparam logic [12:0] OFF_MEPC     = 13'h008;
    localparam logic [12:0] OFF_MCAUSE   = 13'h00C;
    localparam logic [12:0] OFF_MCYCLE   = 13'h010;
    localparam logic [12:0] OFF_MTIMECMP = 13'h014;
    localparam logic [12:0] OFF_MIP      = 13'h018;

    localparam int MSTATUS_MIE = 0;
    localparam int MSTATUS_TIE = 1;

    // MVEC is 512-byte aligned: low nine bits are hardwired to zero
    localparam logic [31:0] MVEC_MASK = 32'hFFFF_FE00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        SEL_MSTATUS,
        SEL_MVEC,
        SEL_MEPC,
        SEL_MCAUSE,
        SEL_MCYCLE,
        SEL_MTIMECMP,
        SEL_MIP,
        SEL_NONE
    } reg_sel_t;

    function automatic logic [31:0] half_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [1:0]  wen);
        return {wen[1] ? new_val[31:16] : old_val[31:16],
                wen[0] ? new_val[15:0]  : old_val[15:0]};
    endfunction

    function automatic reg_sel_t reg_decode(input logic [10:0] widx);
        reg_sel_t sel;
        sel = SEL_NONE;
        if (widx == OFF_MSTATUS[12:2])  sel = SEL_MSTATUS;
        if (widx == OFF_MVEC[12:2])     sel = SEL_MVEC;
        if (widx == OFF_MEPC[12:2])     sel = SEL_MEPC;
        if (widx == OFF_MCAUSE[12:2])   sel = SEL_MCAUSE;
        if (widx == OFF_MCYCLE[12:2])   sel = SEL_MCYCLE;
        if (widx == OFF_MTIMECMP[12:2]) sel = SEL_MTIMECMP;
        if (widx == OFF_MIP[12:2])      sel = SEL_MIP;
        return sel;
    endfunction

endpackage

// File: rtl/mgmt_regfile_if.sv
// rtl/mgmt_regfile_if.sv - management bus request/response signals
interface mgmt_regfile_if;
    logic        mgmt_req;
    logic [31:0] mgmt_adr;
    logic        mgmt_rwn;
    logic [1:0]  mgmt_wen;
    logic [31:0] mgmt_txd;
    logic        mgmt_ack;
    logic        mgmt_rxe;
    logic [31:0] mgmt_rxd;

    modport master (output mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd,
                    input  mgmt_ack, mgmt_rxe, mgmt_rxd);
    modport slave  (input  mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd,
                    output mgmt_ack, mgmt_rxe, mgmt_rxd);
endinterface

// File: rtl/mgmt_timer.sv
// rtl/mgmt_timer.sv - free-running cycle counter, compare register and timer pending bit
module mgmt_timer
    import mgmt_regfile_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_setn,
    input  logic        tie,
    input  logic [1:0]  cyc_wen,
    input  logic [1:0]  cmp_wen,
    input  logic        tip_clr,
    input  logic [31:0] wdata,
    output logic [31:0] mcycle,
    output logic [31:0] mtimecmp,
    output logic        tip
);

    always_ff @(posedge sys_clk or posedge sys_setn) begin
        if (sys_setn) begin
            mcycle   <= '0;
            mtimecmp <= '0;
            tip      <= 1'b0;
        end else begin
            // unwritten halves keep counting so a half write does not stall the counter
            mcycle   <= half_merge(mcycle + 32'd1, wdata, cyc_wen);
            mtimecmp <= half_merge(mtimecmp, wdata, cmp_wen);
            if (tie && (mcycle == mtimecmp))
                tip <= 1'b1;
            else if (tip_clr)
                tip <= 1'b0;
        end
    end

endmodule

// File: rtl/mgmt_regfile.sv
// rtl/mgmt_regfile.sv - machine-mode management register file on a req/ack bus
module mgmt_regfile
    import mgmt_regfile_pkg::*;
#(
    parameter logic [12:0] ADDR_BASE = 13'h000
) (
    input  logic           sys_clk,
    input  logic           sys_setn,
    mgmt_regfile_if.slave  mgmt,
    input  logic           trap,
    input  logic [31:0]    trap_epc,
    input  logic [5:0]     trap_code,
    output logic           mie,
    output logic [31:0]    mvec,
    output logic [31:0]    mepc,
    output logic           tmr_irq
);

    state_t      state_q, state_d;
    logic [12:0] adr_off;
    logic [10:0] widx_q;
    logic        rwn_q;
    logic [1:0]  wen_q;
    logic [31:0] txd_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    reg_sel_t    sel;
    logic        wr_en;
    logic        tie_q;
    logic        tip;
    logic [5:0]  mcause_q;
    logic [31:0] mcycle;
    logic [31:0] mtimecmp;
    logic        unused_adr;

    assign adr_off    = mgmt.mgmt_adr[12:0] - ADDR_BASE;
    assign unused_adr = ^{mgmt.mgmt_adr[31:13], adr_off[1:0]};
    assign sel        = reg_decode(widx_q);
    assign wr_en      = (state_q == ST_ACK) && !rwn_q;

    always_ff @(posedge sys_clk or posedge sys_setn) begin
        if (sys_setn) begin
            state_q <= ST_IDLE;
            widx_q  <= '0;
            rwn_q   <= 1'b0;
            wen_q   <= '0;
            txd_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && mgmt.mgmt_req) begin
                widx_q <= adr_off[12:2];
                rwn_q  <= mgmt.mgmt_rwn;
                wen_q  <= mgmt.mgmt_wen;
                txd_q  <= mgmt.mgmt_txd;
            end
            // holds read data only for the RESP cycle, zero otherwise
            rdata_q <= ((state_q == ST_ACK) && rwn_q) ? rd_mux : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mgmt.mgmt_req) state_d = ST_ACK;
            ST_ACK:  state_d = rwn_q ? ST_RESP : ST_IDLE;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mgmt.mgmt_ack = (state_q == ST_ACK);
    assign mgmt.mgmt_rxe = (state_q == ST_RESP);
    assign mgmt.mgmt_rxd = rdata_q;

    always_ff @(posedge sys_clk or posedge sys_setn) begin
        if (sys_setn) begin
            mie      <= 1'b0;
            tie_q    <= 1'b0;
            mvec     <= '0;
            mepc     <= '0;
            mcause_q <= '0;
        end else begin
            // a trap overrides any bus write to MSTATUS/MEPC in the same cycle
            if (trap) begin
                mie      <= 1'b0;
                mepc     <= trap_epc;
                mcause_q <= trap_code;
            end else begin
                if (wr_en && (sel == SEL_MSTATUS) && wen_q[0]) begin
                    mie   <= txd_q[MSTATUS_MIE];
                    tie_q <= txd_q[MSTATUS_TIE];
                end
                if (wr_en && (sel == SEL_MEPC))
                    mepc <= half_merge(mepc, txd_q, wen_q);
            end
            if (wr_en && (sel == SEL_MVEC))
                mvec <= half_merge(mvec, txd_q, wen_q) & MVEC_MASK;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_MSTATUS: begin
                rd_mux[MSTATUS_MIE] = mie;
                rd_mux[MSTATUS_TIE] = tie_q;
            end
            SEL_MVEC:     rd_mux = mvec;
            SEL_MEPC:     rd_mux = mepc;
            SEL_MCAUSE:   rd_mux[5:0] = mcause_q;
            SEL_MCYCLE:   rd_mux = mcycle;
            SEL_MTIMECMP: rd_mux = mtimecmp;
            SEL_MIP:      rd_mux[0] = tip;
            default:      rd_mux = '0;
        endcase
    end

    mgmt_timer u_timer (
        .sys_clk  (sys_clk),
        .sys_setn (sys_setn),
        .tie      (tie_q),
        .cyc_wen  ((wr_en && (sel == SEL_MCYCLE))   ? wen_q : 2'b00),
        .cmp_wen  ((wr_en && (sel == SEL_MTIMECMP)) ? wen_q : 2'b00),
        .tip_clr  (wr_en && (sel == SEL_MIP) && wen_q[0] && txd_q[0]),
        .wdata    (txd_q),
        .mcycle   (mcycle),
        .mtimecmp (mtimecmp),
        .tip      (tip)
    );

    assign tmr_irq = tip;

endmodule
